// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: state encoding, command codes and pin decode shared by the RTC bus sequencer
package rtc_bus_pkg;
    localparam int ST_W = 3;
    // States are numbered in bus order, so the FSM can step by increment and RECOVER wraps to IDLE
    localparam logic [ST_W-1:0] S_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] S_A_SETUP  = 3'd1;
    localparam logic [ST_W-1:0] S_A_STROBE = 3'd2;
    localparam logic [ST_W-1:0] S_A_HOLD   = 3'd3;
    localparam logic [ST_W-1:0] S_D_SETUP  = 3'd4;
    localparam logic [ST_W-1:0] S_D_STROBE = 3'd5;
    localparam logic [ST_W-1:0] S_D_HOLD   = 3'd6;
    localparam logic [ST_W-1:0] S_RECOVER  = 3'd7;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    typedef struct packed {
        logic cs_n;
        logic ad_sel;
        logic ale;
        logic wr_n;
        logic rd_n;
        logic ad_oe;
    } pins_t;
    localparam pins_t PINS_IDLE = '{cs_n: 1'b1, ad_sel: 1'b0, ale: 1'b0, wr_n: 1'b1, rd_n: 1'b1, ad_oe: 1'b0};
    // Control pin levels for a given state and transaction direction
    function automatic pins_t pins_for(input logic [ST_W-1:0] st, input logic rd);
        pins_t p;
        p.cs_n   = st == S_IDLE || st == S_RECOVER;
        p.ad_sel = st inside {S_D_SETUP, S_D_STROBE, S_D_HOLD};
        p.ale    = st == S_A_STROBE;
        p.wr_n   = !(st == S_D_STROBE && !rd);
        p.rd_n   = !(st == S_D_STROBE && rd);
        p.ad_oe  = (st inside {S_A_SETUP, S_A_STROBE, S_A_HOLD}) || (p.ad_sel && !rd);
        return p;
    endfunction
endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer: reloadable down-counter flagging the last cycle of a bus phase
module rtc_phase_timer #(
    parameter int PHASE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);
    localparam int CW = $clog2(PHASE_CYC + 1);
    localparam logic [CW-1:0] RELOAD = CW'(PHASE_CYC - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // Reload on phase entry, otherwise count down and rest at zero
    always_comb begin
        cnt_d = load ? RELOAD : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
    end
    // Counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign expired = cnt_q == '0;
endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: runs one read/write on the RTC multiplexed AD bus with fixed phase timing
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PHASE_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cmd,
    input  logic              start,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              cs_n,
    output logic              ad_sel,
    output logic              ale,
    output logic              wr_n,
    output logic              rd_n,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in
);
    logic [ST_W-1:0]   state_q, state_d;
    logic              is_rd_q, is_rd_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, ad_out_q, ad_out_d;
    logic              done_q, done_d, ready_q, ready_d;
    pins_t             pins_q, pins_d;
    logic              expired, accept, a_ph, d_ph;
    // The timer reloads while idle and at every phase boundary, so each state lasts PHASE_CYC cycles
    rtc_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (state_q == S_IDLE || expired),
        .expired (expired)
    );
    // Next state, captures and pin values; pins are decoded from the next state so the
    // registered outputs line up with the state they belong to
    always_comb begin
        accept   = state_q == S_IDLE && start && (cmd == CMD_READ || cmd == CMD_WRITE);
        state_d  = accept ? S_A_SETUP : (state_q != S_IDLE && expired) ? state_q + 3'd1 : state_q;
        is_rd_d  = accept ? cmd == CMD_READ : is_rd_q;
        addr_d   = accept ? addr : addr_q;
        wdata_d  = accept ? wdata : wdata_q;
        rdata_d  = (state_q == S_D_STROBE && expired && is_rd_q) ? ad_in : rdata_q;
        done_d   = state_q == S_RECOVER && expired;
        ready_d  = state_d == S_IDLE;
        pins_d   = pins_for(state_d, is_rd_d);
        a_ph     = state_d inside {S_A_SETUP, S_A_STROBE, S_A_HOLD};
        d_ph     = state_d inside {S_D_SETUP, S_D_STROBE, S_D_HOLD};
        ad_out_d = a_ph ? addr_d : (d_ph && !is_rd_d) ? wdata_d : '0;
    end
    // State, capture and pin registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            is_rd_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            pins_q   <= PINS_IDLE;
            ad_out_q <= '0;
        end else begin
            state_q  <= state_d;
            is_rd_q  <= is_rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            pins_q   <= pins_d;
            ad_out_q <= ad_out_d;
        end
    end
    assign ready  = ready_q;
    assign done   = done_q;
    assign rdata  = rdata_q;
    assign cs_n   = pins_q.cs_n;
    assign ad_sel = pins_q.ad_sel;
    assign ale    = pins_q.ale;
    assign wr_n   = pins_q.wr_n;
    assign rd_n   = pins_q.rd_n;
    assign ad_oe  = pins_q.ad_oe;
    assign ad_out = ad_out_q;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed checks of the RTC bus sequencer with PHASE_CYC=4
module tb_rtc_bus_sequencer;
    logic clk = 0, reset = 1, start = 0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] addr = 0, wdata = 0, ad_in = 8'hA5;
    logic ready, done, cs_n, ad_sel, ale, wr_n, rd_n, ad_oe;
    logic [7:0] rdata, ad_out;
    int checks = 0, errors = 0;
    int cyc, n_ale, n_ale_ok, n_wr, n_wr_ok, n_rd, n_rd_oe0, n_done, done_at;
    logic [7:0] exp_addr, exp_wdata, din_v;

    rtc_bus_sequencer dut (
        .clk(clk), .reset(reset), .cmd(cmd), .start(start), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .cs_n(cs_n), .ad_sel(ad_sel), .ale(ale),
        .wr_n(wr_n), .rd_n(rd_n), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    always #5 clk = ~clk;

    task automatic clear_stats();
        cyc = 0; n_ale = 0; n_ale_ok = 0; n_wr = 0; n_wr_ok = 0;
        n_rd = 0; n_rd_oe0 = 0; n_done = 0; done_at = 0;
    endtask

    task automatic observe(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (ale) begin n_ale++; if (ad_out == exp_addr && ad_oe) n_ale_ok++; end
            if (!wr_n) begin n_wr++; if (ad_out == exp_wdata && ad_oe) n_wr_ok++; end
            if (!rd_n) begin n_rd++; if (!ad_oe) n_rd_oe0++; end
            if (done) begin n_done++; if (done_at == 0) done_at = cyc; end
            checks++;
            if ((!wr_n && !rd_n) || (!rd_n && ad_oe) || (ale && ad_sel) || ((!wr_n || !rd_n) && cs_n)) begin
                errors++;
                $display("FAIL invariant cyc=%0d got wr_n=%b rd_n=%b ad_oe=%b ale=%b ad_sel=%b cs_n=%b", cyc, wr_n, rd_n, ad_oe, ale, ad_sel, cs_n);
            end
            ad_in = !rd_n ? din_v : 8'hA5;
        end
    endtask

    task automatic test_reset();
        reset = 1; clear_stats();
        observe(3);
        checks++;
        if ({ready, done, rdata, cs_n, ad_sel, ale, wr_n, rd_n, ad_out, ad_oe} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b done=%b rdata=%h cs_n=%b ad_sel=%b ale=%b wr_n=%b rd_n=%b ad_out=%h ad_oe=%b exp reset values",
                     ready, done, rdata, cs_n, ad_sel, ale, wr_n, rd_n, ad_out, ad_oe);
        end
        reset = 0;
    endtask

    task automatic test_write();
        clear_stats(); exp_addr = 8'h21; exp_wdata = 8'h59; din_v = 8'h00;
        cmd = 2'b10; addr = 8'h21; wdata = 8'h59; start = 1;
        observe(1);
        checks++; if (ready !== 1'b0 || cs_n !== 1'b0) begin errors++; $display("FAIL wr_accept got ready=%b cs_n=%b exp 0 0", ready, cs_n); end
        start = 0; cmd = 2'b00;
        observe(31);
        checks++; if (n_ale_ok !== 4 || n_ale !== 4) begin errors++; $display("FAIL wr_ale got %0d/%0d exp 4/4", n_ale_ok, n_ale); end
        checks++; if (n_wr_ok !== 4 || n_wr !== 4) begin errors++; $display("FAIL wr_strobe got %0d/%0d exp 4/4", n_wr_ok, n_wr); end
        checks++; if (n_rd !== 0) begin errors++; $display("FAIL wr_no_rd got %0d exp 0", n_rd); end
        checks++; if (done_at !== 29 || n_done !== 1) begin errors++; $display("FAIL wr_done got at=%0d n=%0d exp 29 1", done_at, n_done); end
        checks++; if (rdata !== 8'h00 || ready !== 1'b1) begin errors++; $display("FAIL wr_end got rdata=%h ready=%b exp 00 1", rdata, ready); end
    endtask

    task automatic test_read();
        clear_stats(); exp_addr = 8'h22; exp_wdata = 8'h00; din_v = 8'h37;
        cmd = 2'b01; addr = 8'h22; wdata = 8'hC3; start = 1;
        observe(1);
        start = 0; cmd = 2'b00;
        observe(31);
        checks++; if (n_ale_ok !== 4) begin errors++; $display("FAIL rd_ale got %0d exp 4", n_ale_ok); end
        checks++; if (n_rd !== 4 || n_rd_oe0 !== 4) begin errors++; $display("FAIL rd_strobe got %0d/%0d exp 4/4", n_rd, n_rd_oe0); end
        checks++; if (n_wr !== 0) begin errors++; $display("FAIL rd_no_wr got %0d exp 0", n_wr); end
        checks++; if (done_at !== 29 || n_done !== 1) begin errors++; $display("FAIL rd_done got at=%0d n=%0d exp 29 1", done_at, n_done); end
        checks++; if (rdata !== 8'h37) begin errors++; $display("FAIL rd_data got %h exp 37", rdata); end
        observe(5);
        checks++; if (rdata !== 8'h37) begin errors++; $display("FAIL rd_hold got %h exp 37", rdata); end
    endtask

    task automatic test_ignored();
        clear_stats();
        for (int i = 0; i < 2; i++) begin
            cmd = i == 0 ? 2'b00 : 2'b11; start = 1;
            observe(3);
            checks++;
            if (ready !== 1'b1 || cs_n !== 1'b1 || n_done !== 0 || n_ale !== 0) begin
                errors++; $display("FAIL noop_cmd%0d got ready=%b cs_n=%b done=%0d ale=%0d exp 1 1 0 0", i, ready, cs_n, n_done, n_ale);
            end
        end
        clear_stats(); exp_addr = 8'h30; exp_wdata = 8'h4C;
        cmd = 2'b10; addr = 8'h30; wdata = 8'h4C;
        observe(1);
        start = 0;
        observe(9);
        cmd = 2'b01; addr = 8'hFF; wdata = 8'hEE; start = 1;
        observe(4);
        start = 0; cmd = 2'b00;
        observe(18);
        checks++; if (done_at !== 29 || n_done !== 1) begin errors++; $display("FAIL busy_done got at=%0d n=%0d exp 29 1", done_at, n_done); end
        checks++; if (n_wr_ok !== 4 || n_ale_ok !== 4) begin errors++; $display("FAIL busy_latch got wr=%0d ale=%0d exp 4 4", n_wr_ok, n_ale_ok); end
        checks++; if (n_rd !== 0) begin errors++; $display("FAIL busy_no_rd got %0d exp 0", n_rd); end
        checks++; if (rdata !== 8'h37 || ready !== 1'b1) begin errors++; $display("FAIL busy_end got rdata=%h ready=%b exp 37 1", rdata, ready); end
    endtask

    task automatic test_reset_mid();
        clear_stats(); exp_addr = 8'h44; din_v = 8'h99;
        cmd = 2'b01; addr = 8'h44; start = 1;
        observe(1);
        start = 0; cmd = 2'b00;
        observe(16);
        checks++; if (rd_n !== 1'b0) begin errors++; $display("FAIL mid_in_strobe got rd_n=%b exp 0", rd_n); end
        reset = 1;
        observe(1);
        checks++;
        if (cs_n !== 1'b1 || rd_n !== 1'b1 || rdata !== 8'h00 || ready !== 1'b1 || done !== 1'b0 || ad_oe !== 1'b0) begin
            errors++; $display("FAIL mid_reset got cs_n=%b rd_n=%b rdata=%h ready=%b done=%b ad_oe=%b exp 1 1 00 1 0 0", cs_n, rd_n, rdata, ready, done, ad_oe);
        end
        reset = 0; clear_stats();
        observe(4);
        checks++; if (n_done !== 0 || rdata !== 8'h00) begin errors++; $display("FAIL mid_after got done=%0d rdata=%h exp 0 00", n_done, rdata); end
    endtask

    task automatic test_back_to_back();
        clear_stats(); exp_addr = 8'h55; din_v = 8'h6A;
        cmd = 2'b01; addr = 8'h55; start = 1;
        observe(29);
        checks++; if (done !== 1'b1 || ready !== 1'b1 || done_at !== 29) begin errors++; $display("FAIL b2b_done1 got done=%b ready=%b at=%0d exp 1 1 29", done, ready, done_at); end
        checks++; if (rdata !== 8'h6A || n_rd !== 4) begin errors++; $display("FAIL b2b_rdata got %h rd=%0d exp 6a 4", rdata, n_rd); end
        cmd = 2'b10; addr = 8'h66; wdata = 8'h77; exp_addr = 8'h66; exp_wdata = 8'h77;
        observe(1);
        checks++; if (cs_n !== 1'b0 || ready !== 1'b0 || done !== 1'b0 || ad_out !== 8'h66) begin
            errors++; $display("FAIL b2b_start2 got cs_n=%b ready=%b done=%b ad_out=%h exp 0 0 0 66", cs_n, ready, done, ad_out);
        end
        start = 0; cmd = 2'b00;
        clear_stats(); cyc = 1;
        observe(29);
        checks++; if (done_at !== 29 || n_done !== 1) begin errors++; $display("FAIL b2b_done2 got at=%0d n=%0d exp 29 1", done_at, n_done); end
        checks++; if (n_wr_ok !== 4 || n_ale_ok !== 4 || n_rd !== 0) begin errors++; $display("FAIL b2b_write got wr=%0d ale=%0d rd=%0d exp 4 4 0", n_wr_ok, n_ale_ok, n_rd); end
        checks++; if (rdata !== 8'h6A) begin errors++; $display("FAIL b2b_rdata_kept got %h exp 6a", rdata); end
    endtask

    initial begin
        exp_addr = 0; exp_wdata = 0; din_v = 0;
        test_reset();
        test_write();
        test_read();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
